// File: rtl/ad80305_dc_cal_ctrl.sv
// DC-offset calibration FSM and correction stage for the AD80305 RX I/Q stream.
// Latency: 1 clock sample-in to sample-out. No backpressure; strobe gaps only stall counting.
// Optional AD80305_DC_CAL_IIR_EN: smooth successive estimates (corr += (est - corr) >>> 2).
module ad80305_dc_cal_ctrl #(
   parameter int DW         = 12,
   parameter int CORR_W     = 8,
   parameter int LOG2_N     = 10,
   parameter int SETTLE_CYC = 256,
   parameter int PERIOD_CYC = 125000
) (
   input  logic              i_fpga_clk_125p,
   input  logic              i_fpga_rst_125p,
   input  logic              i_cal_start,
   input  logic              i_auto_en,
   input  logic              i_dc_bypass,
   input  logic              i_dc_set_sw,
   input  logic [CORR_W-1:0] i_dc_corr_idata,
   input  logic [CORR_W-1:0] i_dc_corr_qdata,
   input  logic              i_iqdata_fp,
   input  logic [DW-1:0]     i_idata,
   input  logic [DW-1:0]     i_qdata,
   output logic              o_iqdata_fp,
   output logic [DW-1:0]     o_idata,
   output logic [DW-1:0]     o_qdata,
   output logic [DW-1:0]     o_aver_idata,
   output logic [DW-1:0]     o_aver_qdata,
   output logic [CORR_W-1:0] o_corr_idata,
   output logic [CORR_W-1:0] o_corr_qdata,
   output logic              o_cal_busy,
   output logic              o_cal_done,
   output logic              o_corr_sat
);

   localparam int AW      = DW + LOG2_N;
   localparam int NSMP    = 1 << LOG2_N;
   localparam int CNT_MAX = (SETTLE_CYC > NSMP) ? SETTLE_CYC : NSMP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int PW      = $clog2(PERIOD_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_ACCUM,
      S_UPDATE,
      S_WAIT
   } state_t;

   state_t                   state, state_nxt;
   logic [CW-1:0]            cnt;
   logic [PW-1:0]            per_cnt;
   logic signed [AW-1:0]     acc_i, acc_q;
   logic [CORR_W-1:0]        corr_i, corr_q;

   logic                     per_exp, settle_last, accum_last;
   logic [DW:0]              dif_i, dif_q;
   logic [DW-1:0]            cor_i, cor_q;
   logic signed [AW-1:0]     mean_i, mean_q;
   logic                     clip_i, clip_q;
   logic signed [CORR_W-1:0] est_i, est_q;
   logic [CORR_W-1:0]        new_i, new_q;

   assign per_exp     = (per_cnt == PW'(PERIOD_CYC - 1));
   assign settle_last = i_iqdata_fp && (cnt == CW'(SETTLE_CYC - 1));
   assign accum_last  = i_iqdata_fp && (cnt == CW'(NSMP - 1));

   // Correction path: one extra bit of headroom, then clip back to DW.
   assign dif_i = {i_idata[DW-1], i_idata} - {{(DW+1-CORR_W){corr_i[CORR_W-1]}}, corr_i};
   assign dif_q = {i_qdata[DW-1], i_qdata} - {{(DW+1-CORR_W){corr_q[CORR_W-1]}}, corr_q};
   assign cor_i = (dif_i[DW] != dif_i[DW-1]) ? {dif_i[DW], {(DW-1){~dif_i[DW]}}} : dif_i[DW-1:0];
   assign cor_q = (dif_q[DW] != dif_q[DW-1]) ? {dif_q[DW], {(DW-1){~dif_q[DW]}}} : dif_q[DW-1:0];

   // Mean fits CORR_W only if every bit above the CORR_W sign bit matches it.
   assign mean_i = acc_i >>> LOG2_N;
   assign mean_q = acc_q >>> LOG2_N;
   assign clip_i = !((&mean_i[AW-1:CORR_W-1]) || !(|mean_i[AW-1:CORR_W-1]));
   assign clip_q = !((&mean_q[AW-1:CORR_W-1]) || !(|mean_q[AW-1:CORR_W-1]));
   assign est_i  = clip_i ? {mean_i[AW-1], {(CORR_W-1){~mean_i[AW-1]}}} : mean_i[CORR_W-1:0];
   assign est_q  = clip_q ? {mean_q[AW-1], {(CORR_W-1){~mean_q[AW-1]}}} : mean_q[CORR_W-1:0];

`ifdef AD80305_DC_CAL_IIR_EN
   logic signed [CORR_W:0] step_i, step_q, sum_i, sum_q;

   assign step_i = ($signed({est_i[CORR_W-1], est_i}) - $signed({corr_i[CORR_W-1], corr_i})) >>> 2;
   assign step_q = ($signed({est_q[CORR_W-1], est_q}) - $signed({corr_q[CORR_W-1], corr_q})) >>> 2;
   assign sum_i  = $signed({corr_i[CORR_W-1], corr_i}) + step_i;
   assign sum_q  = $signed({corr_q[CORR_W-1], corr_q}) + step_q;
   assign new_i  = (sum_i[CORR_W] != sum_i[CORR_W-1]) ?
                   {sum_i[CORR_W], {(CORR_W-1){~sum_i[CORR_W]}}} : sum_i[CORR_W-1:0];
   assign new_q  = (sum_q[CORR_W] != sum_q[CORR_W-1]) ?
                   {sum_q[CORR_W], {(CORR_W-1){~sum_q[CORR_W]}}} : sum_q[CORR_W-1:0];
`else
   assign new_i = est_i;
   assign new_q = est_q;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (!i_dc_set_sw && (i_cal_start || (i_auto_en && per_exp)))
               state_nxt = S_SETTLE;
         S_SETTLE:
            if (i_dc_set_sw)      state_nxt = S_IDLE;
            else if (settle_last) state_nxt = S_ACCUM;
         S_ACCUM:
            if (i_dc_set_sw)      state_nxt = S_IDLE;
            else if (accum_last)  state_nxt = S_UPDATE;
         S_UPDATE:
            if (!i_dc_set_sw && i_auto_en) state_nxt = S_WAIT;
            else                           state_nxt = S_IDLE;
         S_WAIT:
            if (!i_auto_en)
               state_nxt = S_IDLE;
            else if (!i_dc_set_sw && (i_cal_start || per_exp))
               state_nxt = S_SETTLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_fpga_clk_125p) begin
      if (!i_fpga_rst_125p) begin
         state        <= S_IDLE;
         cnt          <= '0;
         per_cnt      <= '0;
         acc_i        <= '0;
         acc_q        <= '0;
         corr_i       <= '0;
         corr_q       <= '0;
         o_iqdata_fp  <= 1'b0;
         o_idata      <= '0;
         o_qdata      <= '0;
         o_aver_idata <= '0;
         o_aver_qdata <= '0;
         o_cal_done   <= 1'b0;
         o_corr_sat   <= 1'b0;
      end else begin
         state      <= state_nxt;
         o_cal_done <= 1'b0;

         if ((state == S_IDLE || state == S_WAIT) && i_auto_en && !per_exp)
            per_cnt <= per_cnt + 1'b1;
         else
            per_cnt <= '0;

         if (state_nxt == S_SETTLE && state != S_SETTLE) begin
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
         end else if (state == S_SETTLE && i_iqdata_fp) begin
            cnt <= settle_last ? '0 : cnt + 1'b1;
         end else if (state == S_ACCUM && i_iqdata_fp) begin
            cnt   <= cnt + 1'b1;
            acc_i <= acc_i + {{LOG2_N{i_idata[DW-1]}}, i_idata};
            acc_q <= acc_q + {{LOG2_N{i_qdata[DW-1]}}, i_qdata};
         end

         // Manual words win over any in-flight estimate.
         if (i_dc_set_sw) begin
            corr_i <= i_dc_corr_idata;
            corr_q <= i_dc_corr_qdata;
         end else if (state == S_UPDATE) begin
            corr_i       <= new_i;
            corr_q       <= new_q;
            o_aver_idata <= mean_i[DW-1:0];
            o_aver_qdata <= mean_q[DW-1:0];
            o_corr_sat   <= clip_i || clip_q;
            o_cal_done   <= 1'b1;
         end

         o_iqdata_fp <= i_iqdata_fp;
         if (i_iqdata_fp) begin
            o_idata <= i_dc_bypass ? i_idata : cor_i;
            o_qdata <= i_dc_bypass ? i_qdata : cor_q;
         end
      end
   end

   assign o_corr_idata = corr_i;
   assign o_corr_qdata = corr_q;
   assign o_cal_busy   = (state == S_SETTLE) || (state == S_ACCUM) || (state == S_UPDATE);

endmodule

// File: tb/tb_ad80305_dc_cal_ctrl.sv
// Scoreboard bench for ad80305_dc_cal_ctrl: expected samples/calibration results are queued at
// stimulus time and popped by a negedge monitor whenever the DUT presents a strobe or done pulse.
module tb_ad80305_dc_cal_ctrl;

   localparam int DW = 12, CORR_W = 8, LOG2_N = 4, SETTLE_CYC = 4, PERIOD_CYC = 50;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_cal_start = 1'b0, i_auto_en = 1'b0, i_dc_bypass = 1'b0, i_dc_set_sw = 1'b0;
   logic [CORR_W-1:0] i_dc_corr_idata = '0, i_dc_corr_qdata = '0;
   logic              i_iqdata_fp = 1'b0;
   logic [DW-1:0]     i_idata = '0, i_qdata = '0;
   logic              o_iqdata_fp, o_cal_busy, o_cal_done, o_corr_sat;
   logic [DW-1:0]     o_idata, o_qdata, o_aver_idata, o_aver_qdata;
   logic [CORR_W-1:0] o_corr_idata, o_corr_qdata;

   ad80305_dc_cal_ctrl #(
      .DW(DW), .CORR_W(CORR_W), .LOG2_N(LOG2_N), .SETTLE_CYC(SETTLE_CYC), .PERIOD_CYC(PERIOD_CYC)
   ) dut (
      .i_fpga_clk_125p(clk),
      .i_fpga_rst_125p(rst_n),
      .i_cal_start(i_cal_start),
      .i_auto_en(i_auto_en),
      .i_dc_bypass(i_dc_bypass),
      .i_dc_set_sw(i_dc_set_sw),
      .i_dc_corr_idata(i_dc_corr_idata),
      .i_dc_corr_qdata(i_dc_corr_qdata),
      .i_iqdata_fp(i_iqdata_fp),
      .i_idata(i_idata),
      .i_qdata(i_qdata),
      .o_iqdata_fp(o_iqdata_fp),
      .o_idata(o_idata),
      .o_qdata(o_qdata),
      .o_aver_idata(o_aver_idata),
      .o_aver_qdata(o_aver_qdata),
      .o_corr_idata(o_corr_idata),
      .o_corr_qdata(o_corr_qdata),
      .o_cal_busy(o_cal_busy),
      .o_cal_done(o_cal_done),
      .o_corr_sat(o_corr_sat)
   );

   always #5 clk = ~clk;

   typedef struct { int i; int q; } smp_t;
   typedef struct { int ai; int aq; int ci; int cq; int sat; } cal_t;

   smp_t data_q[$];
   cal_t cal_q[$];
   int   n_chk = 0, n_pass = 0;
   int   cyc = 0, done_seen = 0, done_cyc = 0, done_gap = 0;
   int   m_ci = 0, m_cq = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s", name);
   endtask

   function automatic int sat_dw(input int x);
      if (x > 2047)  return 2047;
      if (x < -2048) return -2048;
      return x;
   endfunction

   function automatic int s12(input logic [DW-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int s8(input logic [CORR_W-1:0] v);
      return int'($signed(v));
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: pops and compares on every output strobe / done pulse.
   always @(negedge clk) begin
      smp_t e;
      cal_t c;
      if (o_iqdata_fp) begin
         if (data_q.size() == 0) fail_now("unexpected_out_strobe");
         else begin
            e = data_q.pop_front();
            check("out_i", s12(o_idata), e.i);
            check("out_q", s12(o_qdata), e.q);
         end
      end
      if (o_cal_done) begin
         done_seen++;
         done_gap = cyc - done_cyc;
         done_cyc = cyc;
         if (cal_q.size() == 0) fail_now("unexpected_cal_done");
         else begin
            c = cal_q.pop_front();
            check("aver_i", s12(o_aver_idata), c.ai);
            check("aver_q", s12(o_aver_qdata), c.aq);
            check("corr_i", s8(o_corr_idata), c.ci);
            check("corr_q", s8(o_corr_qdata), c.cq);
            check("corr_sat", int'(o_corr_sat), c.sat);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input int i, input int q);
      smp_t e;
      i_iqdata_fp = 1'b1;
      i_idata = DW'(i);
      i_qdata = DW'(q);
      e.i = i_dc_bypass ? i : sat_dw(i - m_ci);
      e.q = i_dc_bypass ? q : sat_dw(q - m_cq);
      data_q.push_back(e);
      step(1);
      i_iqdata_fp = 1'b0;
   endtask

   task automatic pulse_start();
      i_cal_start = 1'b1;
      step(1);
      i_cal_start = 1'b0;
   endtask

   task automatic expect_cal(input int ai, input int aq, input int ci, input int cq, input int sat);
      cal_t c;
      c.ai = ai; c.aq = aq; c.ci = ci; c.cq = cq; c.sat = sat;
      cal_q.push_back(c);
   endtask

   task automatic wait_done(input int target, input int limit);
      int k = 0;
      while (done_seen < target && k < limit) begin step(1); k++; end
      if (done_seen < target) fail_now("cal_done_timeout");
   endtask

   initial begin
      step(2);
      check("rst_out_i", s12(o_idata), 0);
      check("rst_corr_i", s8(o_corr_idata), 0);
      check("rst_aver_i", s12(o_aver_idata), 0);
      check("rst_busy", int'(o_cal_busy), 0);
      check("rst_done", int'(o_cal_done), 0);
      rst_n = 1'b1;
      step(1);

      // Constant input calibration, done one clock after the 20th strobe.
      expect_cal(20, -7, 20, -7, 0);
      pulse_start();
      for (int k = 0; k < 20; k++) send(20, -7);
      check("t1_update_no_done", int'(o_cal_done), 0);
      check("t1_update_busy", int'(o_cal_busy), 1);
      step(1);
      check("t1_done_pulse", int'(o_cal_done), 1);
      step(1);
      check("t1_done_one_clk", int'(o_cal_done), 0);
      check("t1_idle_busy", int'(o_cal_busy), 0);
      m_ci = 20; m_cq = -7;
      send(20, -7);
      send(20, -7);

      // Saturated estimate; 21st strobe lands on the UPDATE clock and uses old corr.
      expect_cal(300, -400, 127, -128, 1);
      pulse_start();
      for (int k = 0; k < 21; k++) send(300, -400);
      wait_done(2, 10);
      m_ci = 127; m_cq = -128;
      send(300, -400);

      // Floor averaging: -8 >>> 4 = -1.
      expect_cal(-1, 3, -1, 3, 0);
      pulse_start();
      for (int k = 0; k < 20; k++) send((k % 2 == 1) ? -2 : 1, 3);
      wait_done(3, 10);
      m_ci = -1; m_cq = 3;

      // Manual override aborts mid-ACCUM.
      pulse_start();
      for (int k = 0; k < 8; k++) send(5, 5);
      i_dc_set_sw = 1'b1;
      i_dc_corr_idata = 8'sd5;
      i_dc_corr_qdata = -8'sd3;
      step(1);
      check("t4_abort_busy", int'(o_cal_busy), 0);
      check("t4_corr_i", s8(o_corr_idata), 5);
      check("t4_corr_q", s8(o_corr_qdata), -3);
      check("t4_aver_i_kept", s12(o_aver_idata), -1);
      check("t4_aver_q_kept", s12(o_aver_qdata), 3);
      m_ci = 5; m_cq = -3;
      send(10, 10);
      pulse_start();
      check("t4_start_blocked", int'(o_cal_busy), 0);
      i_dc_set_sw = 1'b0;
      step(30);
      check("t4_corr_i_held", s8(o_corr_idata), 5);

      // Auto recalibration with bypass: output is raw, dones 50+4+16+1 clocks apart.
      i_dc_bypass = 1'b1;
      expect_cal(4, -4, 4, -4, 0);
      expect_cal(4, -4, 4, -4, 0);
      i_auto_en = 1'b1;
      for (int k = 0; k < 400 && done_seen < 5; k++) send(4, -4);
      i_auto_en = 1'b0;
      if (done_seen < 5) fail_now("t5_auto_timeout");
      else check("t5_auto_gap", done_gap, 71);
      i_dc_bypass = 1'b0;
      m_ci = 4; m_cq = -4;
      step(2);

      // Reset in the middle of ACCUM.
      pulse_start();
      for (int k = 0; k < 8; k++) send(10, -10);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("t6_rst_out_i", s12(o_idata), 0);
      check("t6_rst_out_q", s12(o_qdata), 0);
      check("t6_rst_corr_q", s8(o_corr_qdata), 0);
      check("t6_rst_aver_q", s12(o_aver_qdata), 0);
      check("t6_rst_busy", int'(o_cal_busy), 0);
      m_ci = 0; m_cq = 0;
      for (int k = 0; k < 30; k++) send(7, 7);
      check("t6_no_spont_done", done_seen, 5);
      expect_cal(7, 7, 7, 7, 0);
      pulse_start();
      for (int k = 0; k < 20; k++) send(7, 7);
      wait_done(6, 10);

      step(3);
      check("data_q_drained", data_q.size(), 0);
      check("cal_q_drained", cal_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ad80305_dc_cal_ctrl.md
Name: ad80305_dc_cal_ctrl

Overview:
DC-offset calibration controller and correction stage for the AD80305 RX path in the i_fpga_clk_125p domain. It sits after the RX interface, on the deinterleaved I/Q with its frame strobe.
- Sequences periodic or on-demand offset estimation: settle, accumulate, average.
- Holds the active correction value and applies it to the sample stream.
- A manual override lets software force the correction words directly.

Parameters:
DW, 12, I/Q sample width (signed)
CORR_W, 8, correction word width (signed)
LOG2_N, 10, log2 of samples averaged per calibration
SETTLE_CYC, 256, strobes discarded before accumulation
PERIOD_CYC, 125000, clocks between automatic recalibrations

Ports:
i_fpga_clk_125p  in  1  system clock, 125 MHz
i_fpga_rst_125p  in  1  synchronous active-low reset
i_cal_start  in  1  one-clock calibration request
i_auto_en  in  1  enable periodic recalibration
i_dc_bypass  in  1  1 = pass samples uncorrected
i_dc_set_sw  in  1  1 = manual correction from i_dc_corr_*
i_dc_corr_idata  in  CORR_W  manual I correction (signed)
i_dc_corr_qdata  in  CORR_W  manual Q correction (signed)
i_iqdata_fp  in  1  sample-valid strobe
i_idata  in  DW  raw I (signed)
i_qdata  in  DW  raw Q (signed)
o_iqdata_fp  out  1  corrected-sample strobe
o_idata  out  DW  corrected I
o_qdata  out  DW  corrected Q
o_aver_idata  out  DW  last measured I mean
o_aver_qdata  out  DW  last measured Q mean
o_corr_idata  out  CORR_W  active I correction
o_corr_qdata  out  CORR_W  active Q correction
o_cal_busy  out  1  FSM outside IDLE/WAIT
o_cal_done  out  1  one-clock pulse on correction update
o_corr_sat  out  1  last estimate clipped to CORR_W range

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-low. When i_fpga_rst_125p=0 at an edge, all outputs and state clear to 0 and the FSM enters IDLE.
- Datapath (1-clock latency):
  - o_iqdata_fp = registered i_iqdata_fp.
  - If i_dc_bypass=1: o_idata/o_qdata = registered input.
  - Otherwise: output = sat_DW(input − sign_ext(active corr)). Saturation limits are −2^(DW−1) to 2^(DW−1)−1.
  - Data registers update only on strobe.
- Active correction:
  - i_dc_set_sw=1: loaded from i_dc_corr_* every clock.
  - Otherwise: updated only in UPDATE.
- FSM states:
  - IDLE: go to SETTLE on i_cal_start=1, or when i_auto_en=1 and the period counter expires. Entry is blocked while i_dc_set_sw=1.
  - SETTLE: count SETTLE_CYC strobes, then go to ACCUM. Accumulators and the strobe counter clear on entry.
  - ACCUM: on each strobe, add raw (pre-correction) i_idata/i_qdata, sign-extended to DW+LOG2_N bits. After the 2^LOG2_N-th strobe, go to UPDATE.
  - UPDATE (1 clock):
    - mean = acc >>> LOG2_N (arithmetic shift, floor) → o_aver_*.
    - est = sat_CORR_W(mean); o_corr_sat=1 if either channel clipped.
    - Active corr = est; o_cal_done=1.
    - Next state: WAIT if i_auto_en=1, else IDLE.
  - WAIT: the period counter runs PERIOD_CYC clocks, then go to SETTLE. Drop to IDLE if i_auto_en=0. i_cal_start in WAIT goes to SETTLE immediately.
- o_cal_busy=1 in SETTLE, ACCUM and UPDATE.
- Boundary conditions:
  - i_cal_start while busy is ignored.
  - i_dc_set_sw rising mid-calibration aborts to IDLE: no o_cal_done, o_aver_* unchanged, accumulators discarded.
  - i_dc_bypass does not affect calibration.
  - Strobe gaps only stall counting; no timeout.
  - A strobe coinciding with the UPDATE clock is corrected with the old corr value.

Optional Feature:
Macro AD80305_DC_CAL_IIR_EN.
- Defined: UPDATE loads corr_new = corr_old + ((est − corr_old) >>> 2), computed at CORR_W+1 bits and saturated to CORR_W. This gives first-order smoothing across calibrations. o_aver_* still report the raw mean.
- Undefined: corr_new = est (direct load).

Test Plan:
- Calibration, constant input: LOG2_N=4, SETTLE_CYC=4, strobe every clock, I=+20, Q=−7, pulse i_cal_start → o_cal_done exactly once, 1 clock after the 20th strobe; o_aver=20/−7; o_corr=20/−7; next samples output 0/0; o_corr_sat=0.
- Saturation: I=+300, Q=−400 → o_aver=300/−400; o_corr=127/−128; o_corr_sat=1; output I=173, Q=−272.
- Floor averaging: alternate I=+1/−2 for 16 samples → o_aver_idata=−1 (−8>>>4 floors).
- Manual abort: i_dc_set_sw=1 during ACCUM with i_dc_corr=5/−3 → FSM IDLE next clock; no done; o_corr=5/−3; input 10/10 outputs 5/13.
- Auto and bypass: i_auto_en=1, PERIOD_CYC=50 → repeated o_cal_done pulses spaced 50 clks + cal time. With i_dc_bypass=1 the output equals input while calibrations still complete.
- Reset mid-ACCUM: drive i_fpga_rst_125p=0 for 1 clock → all outputs 0, FSM IDLE; no done until the next i_cal_start.
